// File: rtl/frog_sprite_renderer_pkg.sv
// Shared frog constants: facing encodings, grid and screen geometry, start position,
// and the sprite ROM image (frame 0 = sitting, frame 1 = mid-hop).
package frog_sprite_renderer_pkg;

    typedef enum logic [1:0] {
        FACE_UP    = 2'd0,
        FACE_DOWN  = 2'd1,
        FACE_LEFT  = 2'd2,
        FACE_RIGHT = 2'd3
    } facing_t;

    localparam int GRID_PX      = 32;
    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int FROG_START_X = 320;
    localparam int FROG_START_Y = 448;

    // addr = {frame, row[3:0], col[3:0]}; row 0 is the head end of the sprite.
    function automatic logic sprite_bit(input logic [8:0] addr);
        logic       frame;
        logic [3:0] row;
        logic [3:0] col;
        logic       bit_v;
        frame = addr[8];
        row   = addr[7:4];
        col   = addr[3:0];
        bit_v = (row >= 4'd1 && row <= 4'd13 && col >= 4'd3 && col <= 4'd12) ||
                (row == 4'd0 && (col == 4'd7 || col == 4'd8));
        if (row == 4'd14) begin
            // legs tucked in while sitting, splayed out while hopping
            bit_v = frame ? (col <= 4'd2 || col >= 4'd13)
                          : (col == 4'd4 || col == 4'd5 || col == 4'd10 || col == 4'd11);
        end
        return bit_v;
    endfunction

endpackage

// File: rtl/frog_sprite_renderer_if.sv
// Frog position and VGA scan bus feeding the sprite renderer.
interface frog_sprite_renderer_if;
    logic [9:0] frog_x;
    logic [9:0] frog_y;
    logic       frame_start;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       pix_valid;

    modport master (output frog_x, frog_y, frame_start, pix_x, pix_y, pix_valid);
    modport slave  (input  frog_x, frog_y, frame_start, pix_x, pix_y, pix_valid);
endinterface

// File: rtl/frog_sprite_rom.sv
// 512x1 frog sprite ROM, synchronous read with one cycle of latency.
module frog_sprite_rom
    import frog_sprite_renderer_pkg::*;
(
    input  logic       clk,
    input  logic [8:0] addr,
    output logic       data
);

    always_ff @(posedge clk) begin
        data <= sprite_bit(addr);
    end

endmodule

// File: rtl/frog_sprite_renderer.sv
// Frog sprite renderer: per-frame position latch, facing/hop tracking, 2-stage pixel pipeline.
// Hop animation (FSM, hop counter, ROM frame select) is built only with FROG_HOP_ANIM_EN defined.
module frog_sprite_renderer
    import frog_sprite_renderer_pkg::*;
#(
    parameter int         SPRITE_PX  = GRID_PX,
    parameter int         HOP_FRAMES = 6,
    parameter logic [2:0] FROG_RGB   = 3'b010,
    parameter logic [9:0] RESET_X    = 10'(FROG_START_X),
    parameter logic [9:0] RESET_Y    = 10'(FROG_START_Y)
) (
    input  logic                    clk,
    input  logic                    reset,
    frog_sprite_renderer_if.slave   bus,
    output logic                    frog_on,
    output logic [2:0]              frog_rgb,
    output logic [1:0]              facing,
    output logic                    hopping
);

    localparam logic [9:0] SPRITE_W = 10'(SPRITE_PX);

    logic [9:0] pos_x;
    logic [9:0] pos_y;
    facing_t    face_q;
    facing_t    face_next;
    logic       moved;
    logic       frame_sel;

    assign moved = (bus.frog_x != pos_x) || (bus.frog_y != pos_y);

    // vertical motion wins over horizontal when both change in one frame
    always_comb begin
        face_next = face_q;
        if (bus.frog_y < pos_y)       face_next = FACE_UP;
        else if (bus.frog_y > pos_y)  face_next = FACE_DOWN;
        else if (bus.frog_x < pos_x)  face_next = FACE_LEFT;
        else if (bus.frog_x > pos_x)  face_next = FACE_RIGHT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_x  <= RESET_X;
            pos_y  <= RESET_Y;
            face_q <= FACE_UP;
        end else if (bus.frame_start) begin
            pos_x  <= bus.frog_x;
            pos_y  <= bus.frog_y;
            face_q <= face_next;
        end
    end

`ifdef FROG_HOP_ANIM_EN
    typedef enum logic {SIT, HOP} hop_state_t;
    hop_state_t state;
    logic [3:0] hop_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SIT;
            hop_cnt <= 4'd0;
        end else if (bus.frame_start) begin
            case (state)
                SIT: begin
                    if (moved) begin
                        state   <= HOP;
                        hop_cnt <= 4'(HOP_FRAMES - 1);
                    end
                end
                HOP: begin
                    if (moved)               hop_cnt <= 4'(HOP_FRAMES - 1);
                    else if (hop_cnt == 4'd0) state   <= SIT;
                    else                     hop_cnt <= hop_cnt - 4'd1;
                end
                default: state <= SIT;
            endcase
        end
    end

    assign frame_sel = (state == HOP);
`else
    assign frame_sel = 1'b0;
`endif

    assign facing  = face_q;
    assign hopping = frame_sel;

    logic [9:0] dx;
    logic [9:0] dy;
    logic       in_box;
    logic [3:0] u;
    logic [3:0] v;
    logic [3:0] row;
    logic [3:0] col;

    // bounds are checked before the difference is trusted, so no 10-bit wrap leaks in
    assign dx     = bus.pix_x - pos_x;
    assign dy     = bus.pix_y - pos_y;
    assign in_box = bus.pix_valid &&
                    (bus.pix_x >= pos_x) && (dx < SPRITE_W) &&
                    (bus.pix_y >= pos_y) && (dy < SPRITE_W);
    assign u = dx[4:1];
    assign v = dy[4:1];

    always_comb begin
        row = v;
        col = u;
        case (face_q)
            FACE_UP:    begin row = v;         col = u;         end
            FACE_DOWN:  begin row = 4'd15 - v; col = u;         end
            FACE_LEFT:  begin row = u;         col = v;         end
            FACE_RIGHT: begin row = 4'd15 - u; col = 4'd15 - v; end
            default:    begin row = v;         col = u;         end
        endcase
    end

    logic       in_box_q;
    logic [8:0] addr_q;
    logic       in_box_d;
    logic       rom_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_box_q <= 1'b0;
            addr_q   <= 9'd0;
            in_box_d <= 1'b0;
        end else begin
            in_box_q <= in_box;
            addr_q   <= {frame_sel, row, col};
            in_box_d <= in_box_q;
        end
    end

    frog_sprite_rom u_rom (
        .clk  (clk),
        .addr (addr_q),
        .data (rom_bit)
    );

    assign frog_on  = in_box_d & rom_bit;
    assign frog_rgb = frog_on ? FROG_RGB : 3'b000;

endmodule
